wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
Writeback stage directly downstream of the M/WB pipeline register. Consumes the registered WB-stage control flags and data, selects the writeback value, commits it to an 8-entry x 64-bit register file, and serves two decode-stage read ports with same-cycle write bypass. Also provides a registered last-write record for EX forwarding, a retired-instruction counter and a registered debug read port.

Parameters:
DATA_W, 64, datapath and register width
REG_ADDR_W, 3, register address width
NUM_REGS, 8, register count (2**REG_ADDR_W)
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
NOOP_WB  in  1  bubble/no-op flag
ADDI_WB  in  1  ADDI in WB
MOVI_WB  in  1  MOVI in WB
LW_WB  in  1  load in WB
SW_WB  in  1  store in WB (never writes regfile)
WRE_WB  in  1  register write enable from decode
D_out_WB  in  DATA_W  data memory read value
ALU_result_WB  in  DATA_W  ALU result
Offset_WB  in  DATA_W  sign-extended immediate
rt_WB  in  REG_ADDR_W  destination register
rs_addr  in  REG_ADDR_W  decode read port A address
rt_addr  in  REG_ADDR_W  decode read port B address
rs_data  out  DATA_W  read port A data (combinational)
rt_data  out  DATA_W  read port B data (combinational)
fwd_valid  out  1  registered: a write committed last cycle
fwd_addr  out  REG_ADDR_W  registered: last written register
fwd_data  out  DATA_W  registered: last written value
retire_cnt  out  CNT_W  retired-instruction count
dbg_addr  in  REG_ADDR_W  debug read address
dbg_data  out  DATA_W  registered debug read data

Behaviour:
- Write value select, priority: LW_WB -> D_out_WB; else MOVI_WB -> Offset_WB; else ADDI_WB -> ALU_result_WB; else ALU_result_WB (R-type).
- wr_en = WRE_WB & ~NOOP_WB & ~SW_WB & (rt_WB != 0). R0 hardwired zero; writes to R0 dropped, reads of R0 return 0.
- Commit on rising edge when wr_en; value visible in storage next cycle.
- Read ports: combinational; if addr == rt_WB and wr_en, return write value (bypass) in the same cycle; else storage; addr 0 always 0.
- fwd_valid/addr/data: register wr_en, rt_WB, write value each cycle; fwd_addr/fwd_data hold previous value when wr_en=0 (only fwd_valid drops).
- retire_cnt: +1 each cycle with ~NOOP_WB & (ADDI|MOVI|LW|SW|WRE); all-zero bubble not counted; saturates at 2**CNT_W-1, no wrap.
- dbg_data: registered storage read of dbg_addr, 1-cycle latency, no bypass (reflects state before same-cycle write).
- Reset (rst=1 at edge): all registers 0, fwd_valid 0, fwd_addr 0, fwd_data 0, retire_cnt 0, dbg_data 0. Reset overrides a simultaneous write; WB inputs asserted during reset are discarded, not retired.
- Both read ports may address the same register; both return identical data.
- Multiple type flags asserted simultaneously: priority above applies, counted once.

Test Plan:
- Reset 1 cycle, then idle -> all rs/rt/dbg reads 0, retire_cnt 0, fwd_valid 0.
- MOVI_WB=1, WRE_WB=1, Offset_WB=9, D_out_WB=123, rt_WB=1 -> same cycle rs_addr=1 reads 9 (bypass); next cycle storage R1=9, fwd_valid=1, fwd_addr=1, fwd_data=9, retire_cnt=1.
- NOOP_WB=1, WRE_WB=1, rt_WB=1, D_out_WB=323 for 2 cycles -> R1 stays 9, fwd_valid=0, retire_cnt unchanged.
- ADDI_WB=1, WRE_WB=1, ALU_result_WB=1, Offset_WB=1, rt_WB=3 -> R3=1; LW_WB=1, WRE_WB=1, D_out_WB=0xDEAD, ALU_result_WB=5, rt_WB=3 -> R3=0xDEAD; dbg_addr=3 shows value one cycle later.
- SW_WB=1, WRE_WB=1, rt_WB=2 and MOVI to rt_WB=0 with Offset_WB=7 -> R2 and R0 remain 0, both counted in retire_cnt.
- Assert rst on same edge as MOVI to rt_WB=4 -> R4=0, retire_cnt=0; force retire_cnt to max via CNT_W=4 build and 20 retirements -> holds 15.

Source files
------------

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: writeback select into an 8x64 regfile with bypassed reads, forwarding record, retire counter and debug read
module wb_regfile_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_REGS   = 2**REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  NOOP_WB,
  input  logic                  ADDI_WB,
  input  logic                  MOVI_WB,
  input  logic                  LW_WB,
  input  logic                  SW_WB,
  input  logic                  WRE_WB,
  input  logic [DATA_W-1:0]     D_out_WB,
  input  logic [DATA_W-1:0]     ALU_result_WB,
  input  logic [DATA_W-1:0]     Offset_WB,
  input  logic [REG_ADDR_W-1:0] rt_WB,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      retire_cnt,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];
  logic                  fwd_valid_q, fwd_valid_d;
  logic [REG_ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0]     fwd_data_q, fwd_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     dbg_q, dbg_d;
  logic [DATA_W-1:0]     wr_val;
  logic                  wr_en, retire;
  always_comb begin
    wr_val = LW_WB ? D_out_WB : MOVI_WB ? Offset_WB : ALU_result_WB;
    wr_en = WRE_WB & ~NOOP_WB & ~SW_WB & (rt_WB != '0);
    retire = ~NOOP_WB & (ADDI_WB | MOVI_WB | LW_WB | SW_WB | WRE_WB);
    regs_d = regs_q;
    if (wr_en) regs_d[rt_WB] = wr_val;
    fwd_valid_d = wr_en;
    fwd_addr_d = wr_en ? rt_WB : fwd_addr_q;
    fwd_data_d = wr_en ? wr_val : fwd_data_q;
    cnt_d = (retire && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    dbg_d = regs_q[dbg_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      cnt_q       <= '0;
      dbg_q       <= '0;
    end else begin
      regs_q      <= regs_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      cnt_q       <= cnt_d;
      dbg_q       <= dbg_d;
    end
  end
  assign rs_data    = rs_addr == '0 ? '0 : (wr_en && rs_addr == rt_WB) ? wr_val : regs_q[rs_addr];
  assign rt_data    = rt_addr == '0 ? '0 : (wr_en && rt_addr == rt_WB) ? wr_val : regs_q[rt_addr];
  assign fwd_valid  = fwd_valid_q;
  assign fwd_addr   = fwd_addr_q;
  assign fwd_data   = fwd_data_q;
  assign retire_cnt = cnt_q;
  assign dbg_data   = dbg_q;
endmodule

// File: tb/tb_wb_regfile_stage.sv
// tb_wb_regfile_stage: directed and random checks of wb_regfile_stage against an architectural model
module tb_wb_regfile_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        noop, addi, movi, lw, sw, wre;
  logic [63:0] dout, alu, off;
  logic [2:0]  rt, rs_a, rt_a, dbg_a;
  logic [63:0] rs_d, rt_d, fwd_d, dbg_d;
  logic        fwd_v;
  logic [2:0]  fwd_a;
  logic [31:0] cnt;
  logic [63:0] s_rs_d, s_rt_d, s_fwd_d, s_dbg_d;
  logic        s_fwd_v;
  logic [2:0]  s_fwd_a;
  logic [3:0]  s_cnt;
  logic [63:0] m_regs [8];
  logic        m_fv;
  logic [2:0]  m_fa;
  logic [63:0] m_fd, m_dbg;
  longint      m_cnt, m_sat;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk(clk), .rst(rst), .NOOP_WB(noop), .ADDI_WB(addi), .MOVI_WB(movi), .LW_WB(lw), .SW_WB(sw),
    .WRE_WB(wre), .D_out_WB(dout), .ALU_result_WB(alu), .Offset_WB(off), .rt_WB(rt),
    .rs_addr(rs_a), .rt_addr(rt_a), .rs_data(rs_d), .rt_data(rt_d), .fwd_valid(fwd_v),
    .fwd_addr(fwd_a), .fwd_data(fwd_d), .retire_cnt(cnt), .dbg_addr(dbg_a), .dbg_data(dbg_d)
  );

  wb_regfile_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .NOOP_WB(noop), .ADDI_WB(addi), .MOVI_WB(movi), .LW_WB(lw), .SW_WB(sw),
    .WRE_WB(wre), .D_out_WB(dout), .ALU_result_WB(alu), .Offset_WB(off), .rt_WB(rt),
    .rs_addr(rs_a), .rt_addr(rt_a), .rs_data(s_rs_d), .rt_data(s_rt_d), .fwd_valid(s_fwd_v),
    .fwd_addr(s_fwd_a), .fwd_data(s_fwd_d), .retire_cnt(s_cnt), .dbg_addr(dbg_a), .dbg_data(s_dbg_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_val();
    if (lw) return dout;
    if (movi) return off;
    return alu;
  endfunction

  function automatic logic m_wen();
    return wre && !noop && !sw && rt != 3'd0;
  endfunction

  function automatic logic [63:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 64'd0;
    if (m_wen() && a == rt) return m_val();
    return m_regs[a];
  endfunction

  task automatic set_op(input logic n, a, m, l, s, w, input logic [2:0] r,
                        input logic [63:0] d, al, o);
    {noop, addi, movi, lw, sw, wre} = {n, a, m, l, s, w};
    rt = r; dout = d; alu = al; off = o;
  endtask

  task automatic idle();
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic m_reset();
    foreach (m_regs[i]) m_regs[i] = 64'd0;
    m_fv = 0; m_fa = 0; m_fd = 0; m_dbg = 0; m_cnt = 0; m_sat = 0;
  endtask

  task automatic cycle();
    #1;
    chk("rs_read", rs_d, m_read(rs_a));
    chk("rt_read", rt_d, m_read(rt_a));
    @(posedge clk);
    if (rst) m_reset();
    else begin
      m_dbg = m_regs[dbg_a];
      m_fv = m_wen();
      if (m_wen()) begin
        m_regs[rt] = m_val();
        m_fa = rt;
        m_fd = m_val();
      end
      if (!noop && (addi || movi || lw || sw || wre)) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_sat < 15) m_sat++;
      end
    end
    #1;
    chk("fwd_valid", fwd_v, m_fv);
    chk("fwd_addr", fwd_a, m_fa);
    chk("fwd_data", fwd_d, m_fd);
    chk("retire_cnt", cnt, m_cnt);
    chk("sat_cnt", s_cnt, m_sat);
    chk("dbg_data", dbg_d, m_dbg);
  endtask

  initial begin
    idle();
    rs_a = 0; rt_a = 0; dbg_a = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_reset();
    rs_a = 1; rt_a = 2; dbg_a = 3;
    cycle();
    chk("reset_cnt", cnt, 0);
    chk("reset_fv", fwd_v, 0);
    chk("reset_dbg", dbg_d, 0);
    chk("reset_rs", rs_d, 0);
    set_op(0, 0, 1, 0, 0, 1, 1, 123, 0, 9);
    #1 chk("movi_bypass", rs_d, 9);
    cycle();
    chk("movi_fwd_data", fwd_d, 9);
    chk("movi_fwd_addr", fwd_a, 1);
    chk("movi_cnt", cnt, 1);
    idle();
    #1 chk("r1_stored", rs_d, 9);
    set_op(1, 0, 0, 0, 0, 1, 1, 323, 0, 0);
    cycle();
    cycle();
    chk("noop_fv", fwd_v, 0);
    chk("noop_cnt", cnt, 1);
    chk("noop_r1", rs_d, 9);
    set_op(0, 1, 0, 0, 0, 1, 3, 0, 1, 1);
    cycle();
    set_op(0, 0, 0, 1, 0, 1, 3, 64'hDEAD, 5, 0);
    cycle();
    chk("dbg_prewrite", dbg_d, 1);
    idle();
    rs_a = 3;
    cycle();
    chk("dbg_lw", dbg_d, 64'hDEAD);
    chk("r3_lw", rs_d, 64'hDEAD);
    set_op(0, 0, 0, 0, 1, 1, 2, 0, 55, 66);
    cycle();
    set_op(0, 0, 1, 0, 0, 1, 0, 0, 0, 7);
    cycle();
    idle();
    rs_a = 2; rt_a = 0;
    #1;
    chk("sw_r2", rs_d, 0);
    chk("movi_r0", rt_d, 0);
    chk("sw_r0_cnt", cnt, 5);
    rst = 1;
    set_op(0, 0, 1, 0, 0, 1, 4, 0, 0, 64'h44);
    cycle();
    rst = 0;
    idle();
    rs_a = 4;
    #1;
    chk("rst_r4", rs_d, 0);
    chk("rst_cnt", cnt, 0);
    for (int i = 0; i < 20; i++) begin
      set_op(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle();
    end
    chk("sat_hold", s_cnt, 15);
    chk("cnt_20", cnt, 20);
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 40) == 0);
      set_op($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
             3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      rs_a = 3'($urandom_range(0, 7));
      rt_a = ($urandom_range(0, 4) == 0) ? rs_a : 3'($urandom_range(0, 7));
      dbg_a = 3'($urandom_range(0, 7));
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
